// File: rtl/edge_det_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
// Pure declarations: no logic, no latency, no backpressure.
package edge_det_pkg;

   typedef enum logic [1:0] {
      EDGE_OFF  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_e;

   localparam int MAX_SYNC_STAGES = 4;

   function automatic int cnt_width(input int d);
      return (d <= 2) ? 1 : $clog2(d);
   endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One channel: sync chain, debounce filter, edge strobes and a sticky pending flag.
// Level/strobe at edge SYNC_STAGES+DEBOUNCE_CYCLES-1 after input change; no backpressure.
module edge_det_channel
   import edge_det_pkg::*;
#(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 1,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       d_i,
   input  edge_mode_e mode_i,
   input  logic       clr_i,
   output logic       level_o,
   output logic       posedge_stb_o,
   output logic       negedge_stb_o,
   output logic       evt_stb_o,
   output logic       evt_pend_o
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s;
   logic [CW-1:0] cnt_q;
   logic          level_q;
   logic          pos_q;
   logic          neg_q;
   logic          pend_q;
   logic          accept;
   logic          rise_en;
   logic          fall_en;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = d_i;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               sync_q <= {SYNC_STAGES{RESET_LEVEL}};
            end else begin
               sync_q <= (sync_q << 1) | SYNC_STAGES'(d_i);
            end
         end
         assign s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // A new value is taken once it has differed from the level for DEBOUNCE_CYCLES edges.
   assign accept  = (s != level_q) && (cnt_q == CNT_LAST);
   assign rise_en = (mode_i == EDGE_RISE) || (mode_i == EDGE_BOTH);
   assign fall_en = (mode_i == EDGE_FALL) || (mode_i == EDGE_BOTH);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         level_q <= RESET_LEVEL;
         pos_q   <= 1'b0;
         neg_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         pos_q  <= accept & s;
         neg_q  <= accept & ~s;
         pend_q <= evt_stb_o | (pend_q & ~clr_i);
         if (s == level_q) begin
            cnt_q <= '0;
         end else if (accept) begin
            level_q <= s;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign level_o       = level_q;
   assign posedge_stb_o = pos_q;
   assign negedge_stb_o = neg_q;
   assign evt_stb_o     = (pos_q & rise_en) | (neg_q & fall_en);
   assign evt_pend_o    = pend_q;

endmodule

// File: rtl/edge_detector_multi.sv
// CH_NUM independent debounced edge detectors with a combined event strobe.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES-1 edges per channel; no backpressure, strobes are one-shot.
module edge_detector_multi
   import edge_det_pkg::*;
#(
   parameter int   CH_NUM          = 4,
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 1,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic       [CH_NUM-1:0] d_i,
   input  edge_mode_e [CH_NUM-1:0] mode_i,
   input  logic       [CH_NUM-1:0] clr_i,
   output logic       [CH_NUM-1:0] level_o,
   output logic       [CH_NUM-1:0] posedge_stb_o,
   output logic       [CH_NUM-1:0] negedge_stb_o,
   output logic       [CH_NUM-1:0] evt_stb_o,
   output logic       [CH_NUM-1:0] evt_pend_o,
   output logic                    any_evt_o
);

   generate
      if (CH_NUM < 1) begin : g_bad_ch
         $fatal(1, "edge_detector_multi: CH_NUM must be >= 1");
      end
      if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
         $fatal(1, "edge_detector_multi: DEBOUNCE_CYCLES must be >= 1");
      end
      if (SYNC_STAGES < 0 || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
         $fatal(1, "edge_detector_multi: SYNC_STAGES must be 0..4");
      end
   endgenerate

   for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
      edge_det_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_LEVEL     (RESET_LEVEL)
      ) u_ch (
         .clk_i         (clk_i),
         .rst_ni        (rst_ni),
         .d_i           (d_i[gi]),
         .mode_i        (mode_i[gi]),
         .clr_i         (clr_i[gi]),
         .level_o       (level_o[gi]),
         .posedge_stb_o (posedge_stb_o[gi]),
         .negedge_stb_o (negedge_stb_o[gi]),
         .evt_stb_o     (evt_stb_o[gi]),
         .evt_pend_o    (evt_pend_o[gi])
      );
   end

   assign any_evt_o = |evt_stb_o;

endmodule

// File: doc/edge_detector_multi.md
Name: edge_detector_multi

Overview:
Parametrised, multi-channel successor to posedge_detector. Each channel has an optional input synchroniser, a debounce filter, and rising, falling and selectable-edge one-cycle strobes. Each channel also has a sticky pending flag with a clear input. It sits between raw button/switch/async inputs and the stopwatch/game control FSMs. Those FSMs consume only the strobes or pending flags.

Parameters:
CH_NUM, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, flops in the input synchroniser chain per channel (0 = bypass, max 4)
DEBOUNCE_CYCLES, 1, consecutive cycles a new synchronised value must hold before it is accepted (>=1; 1 = no filtering)
RESET_LEVEL, 1'b0, value loaded into the synchroniser chain and accepted level at reset

Ports:
clk_i  in  1  system clock, all logic on posedge
rst_ni  in  1  asynchronous active-low reset
d_i  in  CH_NUM  raw inputs, may be asynchronous
mode_i  in  CH_NUM x 2  per-channel edge select (edge_mode_e): 00 OFF, 01 RISE, 10 FALL, 11 BOTH
clr_i  in  CH_NUM  per-channel clear pulse for evt_pend_o
level_o  out  CH_NUM  accepted (debounced) level
posedge_stb_o  out  CH_NUM  one-cycle strobe when level_o goes 0->1
negedge_stb_o  out  CH_NUM  one-cycle strobe when level_o goes 1->0
evt_stb_o  out  CH_NUM  (posedge_stb & mode[0]) | (negedge_stb & mode[1])
evt_pend_o  out  CH_NUM  sticky flag, set by evt_stb_o
any_evt_o  out  1  OR of evt_stb_o

Behaviour:
- Reset (rst_ni low, async): sync flops = RESET_LEVEL; level_o = RESET_LEVEL; debounce counters = 0; posedge/negedge strobes = 0; evt_pend_o = 0.
- No strobe may be generated by reset release itself.
- Synchroniser: s = d_i delayed through SYNC_STAGES flops. With SYNC_STAGES = 0, s = d_i.
- Debounce, per channel, each posedge:
  - s == level: cnt <= 0.
  - s != level and cnt == DEBOUNCE_CYCLES-1: level <= s, cnt <= 0, and set the matching strobe flop.
  - Otherwise: cnt <= cnt+1.
- Strobes:
  - posedge_stb_o and negedge_stb_o are registered. They are high only in the cycle in which level_o first shows its new value. They are never high together.
  - Strobes return low the next cycle even if the input stays changed.
- Latency: let edge 0 be the first posedge at which d_i is sampled at its new value. level_o and the strobe update at edge SYNC_STAGES+DEBOUNCE_CYCLES-1, provided the input stays stable throughout.
- Glitches: a pulse on s shorter than DEBOUNCE_CYCLES cycles produces no level change and no strobe; the counter restarts at 0.
- evt_stb_o and any_evt_o are combinational from the registered strobes and the current mode_i. mode_i = OFF masks events but never the posedge/negedge strobes.
- evt_pend_o: set when evt_stb_o = 1; cleared when clr_i = 1. If set and clear occur in the same cycle, set wins. The flag updates the posedge after the strobe cycle.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.
- Counter width: max(1, $clog2(DEBOUNCE_CYCLES)). It saturates by construction and never wraps.
- Elaboration: CH_NUM < 1, DEBOUNCE_CYCLES < 1, or SYNC_STAGES > 4 is a fatal error.

Decomposition:
- Package edge_det_pkg: edge_mode_e (OFF/RISE/FALL/BOTH, 2 bits), MAX_SYNC_STAGES = 4, and a cnt_width(d) function.
- Sub-module edge_det_channel: one channel covering sync chain, debounce counter, level, strobes and pending flag.
- Top level replicates it CH_NUM times via generate and ORs evt_stb_o into any_evt_o.

Test Plan:
1. CH_NUM=1, SYNC_STAGES=0, DEBOUNCE_CYCLES=1, RESET_LEVEL=0: d_i 0->1 before edge 0 -> after edge 0 level_o=1, posedge_stb_o=1. One cycle later posedge_stb_o=0 while d_i and level_o stay 1.
2. SYNC_STAGES=2, DEBOUNCE_CYCLES=3: d_i 0->1 held -> posedge_stb_o high only in the cycle after edge 4. A 2-cycle 1-pulse on d_i -> no strobe, level_o stays 0.
3. mode_i per channel = OFF/RISE/FALL/BOTH; pulse all d_i 0->1->0 -> evt_stb_o on ch1 at rise only, ch2 at fall only, ch3 at both, ch0 never. posedge/negedge strobes fire on all four channels.
4. evt_stb_o on ch2 with clr_i[2]=1 in the same cycle -> evt_pend_o[2]=1. clr_i[2]=1 in a later cycle -> evt_pend_o[2]=0 next cycle. any_evt_o=1 exactly in the strobe cycle.
5. RESET_LEVEL=1 with d_i=1 at reset release -> no strobe. Assert rst_ni mid-debounce (cnt=1) -> all outputs 0/RESET_LEVEL immediately, without waiting for a clock edge.
6. CH_NUM=4, all channels rise in the same cycle -> four simultaneous posedge_stb_o bits and a single any_evt_o cycle.
